// File: rtl/ercm8_v2_0.sv
// Registered 8x8 unsigned multiplier with mask-selectable OR-approximation of columns 0..6.
// Approximation is compiled in only when ERCM8_APPROX_EN is defined; otherwise the block is exact and mask is ignored.
module ercm8_v2_0 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dat_in_a,
    input  logic [7:0]  dat_in_b,
    input  logic [6:0]  mask,
    output logic [15:0] dat_o
);

    localparam int NCOL = 15;

    logic [NCOL-1:0] col_approx;
    logic [3:0]      col_val [NCOL];
    logic [15:0]     prod;

`ifdef ERCM8_APPROX_EN
    assign col_approx = {8'b0, mask};
`else
    logic unused_mask;
    assign unused_mask = ^mask;
    assign col_approx  = '0;
`endif

    // Each column gathers its pp bits into an 8-wide vector indexed by the b row.
    for (genvar j = 0; j < NCOL; j++) begin : g_col
        logic [7:0] bits;
        logic [3:0] cnt;
        for (genvar i = 0; i < 8; i++) begin : g_row
            if ((j - i) >= 0 && (j - i) < 8) begin : g_pp
                assign bits[i] = dat_in_a[j-i] & dat_in_b[i];
            end else begin : g_zero
                assign bits[i] = 1'b0;
            end
        end
        assign cnt        = 4'($countones(bits));
        // An approximated column keeps only the OR, so it never carries upward.
        assign col_val[j] = col_approx[j] ? {3'b0, |bits} : cnt;
    end

    always_comb begin
        prod = '0;
        for (int j = 0; j < NCOL; j++)
            prod = prod + ({12'b0, col_val[j]} << j);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dat_o <= '0;
        else        dat_o <= prod;
    end

endmodule

// File: tb/tb_ercm8_v2_0.sv
// Randomized and directed bench for ercm8_v2_0 against an error-subtraction reference model.
module tb_ercm8_v2_0;

    logic        clk;
    logic        rst_n;
    logic [7:0]  dat_in_a;
    logic [7:0]  dat_in_b;
    logic [6:0]  mask;
    logic [15:0] dat_o;

    int tests = 0;
    int fails = 0;

    ercm8_v2_0 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dat_in_a (dat_in_a),
        .dat_in_b (dat_in_b),
        .mask     (mask),
        .dat_o    (dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact product minus (popcount - OR) * 2^j for each masked low column.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic [6:0] m);
        int p;
        int cnt;
        p = int'(a) * int'(b);
`ifdef ERCM8_APPROX_EN
        for (int j = 0; j < 7; j++) begin
            if (m[j]) begin
                cnt = 0;
                for (int i = 0; i <= j; i++)
                    if (a[j-i] && b[i]) cnt++;
                if (cnt > 1) p = p - (cnt - 1) * (1 << j);
            end
        end
`else
        if (m === 7'bx) p = 0;
`endif
        return p[15:0];
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [6:0] m);
        dat_in_a = a;
        dat_in_b = b;
        mask     = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dat_in_a = 8'd255; dat_in_b = 8'd255; mask = 7'h00;
        #1;
        tests++;
        if (dat_o !== 16'h0000) begin
            fails++; $display("FAIL reset_initial: got %0d want 0", dat_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (dat_o !== 16'd65025) begin
            fails++; $display("FAIL reset_prime: got %0d want 65025", dat_o);
        end
        // Assert asynchronously between edges: output must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (dat_o !== 16'h0000) begin
            fails++; $display("FAIL reset_async: got %0d want 0", dat_o);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (dat_o !== 16'h0000) begin
            fails++; $display("FAIL reset_hold: got %0d want 0", dat_o);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (dat_o !== 16'd65025) begin
            fails++; $display("FAIL reset_release: got %0d want 65025", dat_o);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  ta [7];
        logic [7:0]  tb [7];
        logic [6:0]  tm [7];
        logic [15:0] te [7];
        ta = '{8'd255, 8'd255, 8'd3, 8'd3, 8'd1, 8'd0, 8'd200};
        tb = '{8'd255, 8'd255, 8'd3, 8'd3, 8'd200, 8'd173, 8'd1};
        tm = '{7'h00, 7'h7F, 7'h02, 7'h01, 7'h7F, 7'h7F, 7'h7F};
`ifdef ERCM8_APPROX_EN
        te = '{16'd65025, 16'd64383, 16'd7, 16'd9, 16'd200, 16'd0, 16'd200};
`else
        te = '{16'd65025, 16'd65025, 16'd9, 16'd9, 16'd200, 16'd0, 16'd200};
`endif
        for (int n = 0; n < 7; n++) begin
            drive(ta[n], tb[n], tm[n]);
            tests++;
            if (dat_o !== te[n]) begin
                fails++;
                $display("FAIL directed_%0d: a=%0d b=%0d mask=%h got %0d want %0d",
                         n, ta[n], tb[n], tm[n], dat_o, te[n]);
            end
        end
    endtask

    task automatic test_exact_sweep();
        int errs = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(8'(a), 8'(b), 7'h00);
                if (dat_o !== 16'(a * b)) begin
                    if (errs < 8)
                        $display("FAIL exact_sweep: a=%0d b=%0d got %0d want %0d", a, b, dat_o, a * b);
                    errs++;
                end
            end
        end
        tests++;
        if (errs != 0) fails++;
    endtask

    task automatic test_zero_operand();
        for (int n = 0; n < 16; n++) begin
            logic [7:0] x;
            logic [6:0] m;
            x = 8'($urandom_range(255));
            m = 7'($urandom_range(127));
            drive((n % 2 == 0) ? 8'd0 : x, (n % 2 == 0) ? x : 8'd0, m);
            tests++;
            if (dat_o !== 16'h0000) begin
                fails++; $display("FAIL zero_operand: x=%0d mask=%h got %0d want 0", x, m, dat_o);
            end
        end
    endtask

    task automatic test_pipeline();
        logic [7:0]  a, b;
        logic [6:0]  m;
        logic [15:0] exp_q;
        logic        have = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            a = 8'($urandom); b = 8'($urandom); m = 7'($urandom);
            dat_in_a = a; dat_in_b = b; mask = m;
            if (have) begin
                tests++;
                if (dat_o !== exp_q) begin
                    fails++; $display("FAIL pipeline_%0d: got %0d want %0d", n, dat_o, exp_q);
                end
            end
            @(posedge clk); #1;
            exp_q = ref_mul(a, b, m);
            have  = 1'b1;
            tests++;
            if (int'(dat_o) > int'(a) * int'(b)) begin
                fails++; $display("FAIL pipeline_bound: a=%0d b=%0d got %0d max %0d", a, b, dat_o, a * b);
            end
        end
        tests++;
        if (dat_o !== exp_q) begin
            fails++; $display("FAIL pipeline_last: got %0d want %0d", dat_o, exp_q);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_operand();
        test_exact_sweep();
        test_pipeline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
